// File: rtl/dds_pkg.sv
// dds_pkg: wave-select codes shared by the DDS and a constant function that
// builds the quarter-wave sine table at elaboration time.
package dds_pkg;

  typedef enum logic [1:0] {
    WAVE_SIN = 2'd0,
    WAVE_SQR = 2'd1,
    WAVE_TRI = 2'd2,
    WAVE_SAW = 2'd3
  } wave_e;

  // pi in Q30 fixed point; the table is built with 64-bit integer arithmetic
  // so that elaboration does not depend on real-number math support.
  localparam longint PI_FX = 64'sd3373259426;
  localparam int     FX_SH = 32'sd30;

  // Entry k of the quarter-wave table:
  // round((2^(data_w-1)-1) * sin(pi/2 * (k+0.5) / 2^(addr_w-2))).
  // The half-step offset keeps the table symmetric so that mirroring the
  // index in quadrants 1 and 3 reproduces the wave without a repeated point.
  function automatic int dds_lut_entry(input int k, input int addr_w, input int data_w);
    longint q_len;
    longint x;
    longint x2;
    longint term;
    longint sum;
    longint amp;
    q_len = 64'sd1 <<< (addr_w - 32'sd2);
    // angle = pi * (2k+1) / (4Q), in Q30
    x     = (PI_FX * longint'(32'sd2 * k + 32'sd1)) / (64'sd4 * q_len);
    x2    = (x * x) >>> FX_SH;
    term  = x;
    sum   = x;
    // Taylor series; nine terms are far below one LSB of error for x <= pi/2
    for (int n = 1; n <= 9; n++) begin
      term = -(((term * x2) >>> FX_SH) / longint'((32'sd2 * n) * (32'sd2 * n + 32'sd1)));
      sum  = sum + term;
    end
    amp = (64'sd1 <<< (data_w - 32'sd1)) - 64'sd1;
    return int'((amp * sum + (64'sd1 <<< (FX_SH - 32'sd1))) >>> FX_SH);
  endfunction

endpackage

// File: rtl/dds_sin_lut.sv
// dds_sin_lut: quarter-wave sine ROM, one-cycle registered read, no reset on
// the table or its read register.
module dds_sin_lut
  import dds_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 8
) (
  input  logic              s_clk,
  input  logic [ADDR_W-3:0] i_addr,
  output logic [DATA_W-2:0] o_data
);

  localparam int DEPTH = 32'd1 << (ADDR_W - 2);

  logic [DATA_W-2:0] w_rom [DEPTH];
  logic [DATA_W-2:0] r_data;

  // Table contents are elaboration-time constants.
  for (genvar k = 0; k < DEPTH; k++) begin : g_rom
    localparam int ENTRY = dds_lut_entry(k, ADDR_W, DATA_W);
    assign w_rom[k] = ENTRY[DATA_W-2:0];
  end

  // Synchronous read port.
  always_ff @(posedge s_clk) begin
    r_data <= w_rom[i_addr];
  end

  assign o_data = r_data;

endmodule

// File: rtl/dds_gen.sv
// dds_gen: direct-digital synthesiser. Phase accumulator with programmable
// tuning word, phase offset and four waveforms, three-stage output pipeline.
module dds_gen
  import dds_pkg::*;
#(
  parameter int               ACC_W    = 32,
  parameter int               ADDR_W   = 10,
  parameter int               DATA_W   = 8,
  parameter int               UPD_MODE = 1,
  parameter logic [ACC_W-1:0] RST_FTW  = {ACC_W{1'b0}}
) (
  input  logic              s_clk,
  input  logic              s_rst_n,
  input  logic              en,
  input  logic              phase_clr,
  input  logic              cfg_vld,
  output logic              cfg_rdy,
  input  logic [ACC_W-1:0]  cfg_ftw,
  input  logic [ADDR_W-1:0] cfg_pofs,
  input  logic [1:0]        cfg_wave,
  output logic [DATA_W-1:0] wave_data,
  output logic              wave_vld,
  output logic              wrap
);

  // Config is applied at the accumulator wrap (phase-continuous) instead of
  // on the cycle after acceptance.
  localparam bit MODE_WRAP = (UPD_MODE != 0);

  // ---------------- accumulator and configuration state ----------------
  logic [ACC_W-1:0]  r_acc;
  logic              r_cry;      // the current r_acc was produced by an overflow
  logic [ACC_W-1:0]  r_ftw;
  logic [ADDR_W-1:0] r_pofs;
  wave_e             r_wave;
  logic [ACC_W-1:0]  r_sh_ftw;
  logic [ADDR_W-1:0] r_sh_pofs;
  wave_e             r_sh_wave;
  logic              r_pend;

  logic [ACC_W:0]    w_sum;
  logic              w_carry;
  logic              w_rdy;
  logic              w_accept;
  logic              w_load;

  // Next-phase sum, handshake and the condition that moves shadow to active.
  always_comb begin
    w_sum    = {1'b0, r_acc} + {1'b0, r_ftw};
    w_carry  = w_sum[ACC_W];
    w_rdy    = MODE_WRAP ? ~r_pend : 1'b1;
    w_accept = cfg_vld & w_rdy;
    if (MODE_WRAP) begin
      w_load = r_pend & (phase_clr | (en & w_carry));
    end else begin
      w_load = r_pend;
    end
  end

  // Phase accumulator; phase_clr wins over en and suppresses the carry.
  always_ff @(posedge s_clk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      r_acc <= {ACC_W{1'b0}};
      r_cry <= 1'b0;
    end else if (phase_clr) begin
      r_acc <= {ACC_W{1'b0}};
      r_cry <= 1'b0;
    end else if (en) begin
      r_acc <= w_sum[ACC_W-1:0];
      r_cry <= w_carry;
    end else begin
      r_acc <= r_acc;
      r_cry <= r_cry;
    end
  end

  // Shadow registers capture an accepted configuration.
  always_ff @(posedge s_clk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      r_sh_ftw  <= RST_FTW;
      r_sh_pofs <= {ADDR_W{1'b0}};
      r_sh_wave <= WAVE_SIN;
    end else if (w_accept) begin
      r_sh_ftw  <= cfg_ftw;
      r_sh_pofs <= cfg_pofs;
      r_sh_wave <= wave_e'(cfg_wave);
    end else begin
      r_sh_ftw  <= r_sh_ftw;
      r_sh_pofs <= r_sh_pofs;
      r_sh_wave <= r_sh_wave;
    end
  end

  // Active registers; the accumulator addition on a load edge still uses the
  // old tuning word because w_sum is formed from r_ftw before this update.
  always_ff @(posedge s_clk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      r_ftw  <= RST_FTW;
      r_pofs <= {ADDR_W{1'b0}};
      r_wave <= WAVE_SIN;
    end else if (w_load) begin
      r_ftw  <= r_sh_ftw;
      r_pofs <= r_sh_pofs;
      r_wave <= r_sh_wave;
    end else begin
      r_ftw  <= r_ftw;
      r_pofs <= r_pofs;
      r_wave <= r_wave;
    end
  end

  // Pending flag: set on acceptance, cleared when the shadow is applied. In
  // the immediate mode a new acceptance on the load edge keeps it set.
  always_ff @(posedge s_clk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      r_pend <= 1'b0;
    end else if (w_accept) begin
      r_pend <= 1'b1;
    end else if (w_load) begin
      r_pend <= 1'b0;
    end else begin
      r_pend <= r_pend;
    end
  end

  // ---------------- S1: phase, quadrant and table index ----------------
  logic [ADDR_W-1:0] w_p;
  logic [ADDR_W-3:0] w_idx;

  logic [ADDR_W-1:0] r1_p;
  logic [ADDR_W-3:0] r1_idx;
  wave_e             r1_wave;
  logic              r1_vld;
  logic              r1_wrap;

  // Odd quadrants run the quarter table backwards; Q-1-x equals ~x here.
  always_comb begin
    w_p = r_acc[ACC_W-1 -: ADDR_W] + r_pofs;
    if (w_p[ADDR_W-2]) begin
      w_idx = ~w_p[ADDR_W-3:0];
    end else begin
      w_idx = w_p[ADDR_W-3:0];
    end
  end

  // Stage 1 register; the wrap flag rides with the first post-overflow sample.
  always_ff @(posedge s_clk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      r1_p    <= {ADDR_W{1'b0}};
      r1_idx  <= {(ADDR_W-2){1'b0}};
      r1_wave <= WAVE_SIN;
      r1_vld  <= 1'b0;
      r1_wrap <= 1'b0;
    end else begin
      r1_p    <= w_p;
      r1_idx  <= w_idx;
      r1_wave <= r_wave;
      r1_vld  <= en;
      r1_wrap <= en & r_cry;
    end
  end

  // ---------------- S2: quarter-wave ROM read ----------------
  logic [DATA_W-2:0] w_m;

  logic [ADDR_W-1:0] r2_p;
  wave_e             r2_wave;
  logic              r2_vld;
  logic              r2_wrap;

  dds_sin_lut #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_lut (
    .s_clk  (s_clk),
    .i_addr (r1_idx),
    .o_data (w_m)
  );

  // Stage 2 register, aligned with the ROM's read latency.
  always_ff @(posedge s_clk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      r2_p    <= {ADDR_W{1'b0}};
      r2_wave <= WAVE_SIN;
      r2_vld  <= 1'b0;
      r2_wrap <= 1'b0;
    end else begin
      r2_p    <= r1_p;
      r2_wave <= r1_wave;
      r2_vld  <= r1_vld;
      r2_wrap <= r1_wrap;
    end
  end

  // ---------------- S3: waveform select ----------------
  logic [DATA_W-1:0] w_sel;
  logic [DATA_W-1:0] w_tri;
  logic              w_half;
  logic              w_unused_p;

  logic [DATA_W-1:0] r3_data;
  logic              r3_vld;
  logic              r3_wrap;

  // Output mux; sine is mid+m in the first half and mid-1-m in the second,
  // which in offset binary is just {1,m} and {0,~m}.
  always_comb begin
    w_half     = r2_p[ADDR_W-1];
    w_tri      = r2_p[ADDR_W-2 -: DATA_W];
    w_unused_p = ^r2_p;
    case (r2_wave)
      WAVE_SIN: w_sel = w_half ? {1'b0, ~w_m} : {1'b1, w_m};
      WAVE_SQR: w_sel = {DATA_W{~w_half}};
      WAVE_TRI: w_sel = w_half ? ~w_tri : w_tri;
      WAVE_SAW: w_sel = r2_p[ADDR_W-1 -: DATA_W];
      default:  w_sel = {DATA_W{1'b0}};
    endcase
  end

  // Output register; the sample holds while no valid sample arrives.
  always_ff @(posedge s_clk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      r3_data <= {DATA_W{1'b0}};
      r3_vld  <= 1'b0;
      r3_wrap <= 1'b0;
    end else begin
      r3_data <= r2_vld ? w_sel : r3_data;
      r3_vld  <= r2_vld;
      r3_wrap <= r2_wrap;
    end
  end

  assign cfg_rdy   = w_rdy;
  assign wave_data = r3_data;
  assign wave_vld  = r3_vld;
  assign wrap      = r3_wrap;

endmodule

// File: tb/tb_dds_gen.sv
// tb_dds_gen: directed stimulus on two DDS instances sharing inputs
// (instance 0 applies config immediately, instance 1 at the wrap), checked
// every cycle against a behavioural model plus hand-computed literals.
`timescale 1ns/1ps
module tb_dds_gen;

  localparam int ACC_W  = 32;
  localparam int ADDR_W = 10;
  localparam int DATA_W = 8;
  localparam int NP     = 1024;   // phase steps per cycle
  localparam longint MOD = 64'd4294967296;

  logic              s_clk = 1'b0;
  logic              s_rst_n = 1'b0;
  logic              en = 1'b0;
  logic              phase_clr = 1'b0;
  logic              cfg_vld = 1'b0;
  logic [ACC_W-1:0]  cfg_ftw = 32'd0;
  logic [ADDR_W-1:0] cfg_pofs = 10'd0;
  logic [1:0]        cfg_wave = 2'd0;
  logic [1:0]        cfg_rdy;
  logic [DATA_W-1:0] wave_data [2];
  logic [1:0]        wave_vld;
  logic [1:0]        wrap;

  int checks = 0;
  int errors = 0;

  always #5 s_clk = ~s_clk;

  dds_gen #(.ACC_W(ACC_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .UPD_MODE(0), .RST_FTW(32'd0)) u_dut0 (
    .s_clk(s_clk), .s_rst_n(s_rst_n), .en(en), .phase_clr(phase_clr),
    .cfg_vld(cfg_vld), .cfg_rdy(cfg_rdy[0]), .cfg_ftw(cfg_ftw), .cfg_pofs(cfg_pofs),
    .cfg_wave(cfg_wave), .wave_data(wave_data[0]), .wave_vld(wave_vld[0]), .wrap(wrap[0]));

  dds_gen #(.ACC_W(ACC_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .UPD_MODE(1), .RST_FTW(32'd0)) u_dut1 (
    .s_clk(s_clk), .s_rst_n(s_rst_n), .en(en), .phase_clr(phase_clr),
    .cfg_vld(cfg_vld), .cfg_rdy(cfg_rdy[1]), .cfg_ftw(cfg_ftw), .cfg_pofs(cfg_pofs),
    .cfg_wave(cfg_wave), .wave_data(wave_data[1]), .wave_vld(wave_vld[1]), .wrap(wrap[1]));

  task automatic chk(input string nm, input int inst, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s dut%0d got %0d want %0d at %0t", nm, inst, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Expected sample for phase p straight from the waveform definitions.
  function automatic int exp_sample(input int p, input int w);
    int q, r, k, m, t;
    real th;
    case (w)
      0: begin
        q  = p / 256;
        r  = p % 256;
        k  = (q % 2 == 1) ? 255 - r : r;
        th = 3.14159265358979 / 2.0 * (real'(k) + 0.5) / 256.0;
        m  = $rtoi(127.0 * $sin(th) + 0.5);
        return (q < 2) ? 128 + m : 127 - m;
      end
      1: return (p < NP / 2) ? 255 : 0;
      2: begin
        t = (p / 2) % 256;
        return (p < NP / 2) ? t : 255 - t;
      end
      default: return p / 4;
    endcase
  endfunction

  longint m_acc [2], m_ftw [2], m_sh_ftw [2];
  int     m_pofs [2], m_wave [2], m_sh_pofs [2], m_sh_wave [2];
  bit     m_pend [2], m_cry [2];
  int     dl_p [2][3], dl_w [2][3];
  bit     dl_v [2][3], dl_r [2][3];
  int     e_data [2];
  bit     e_vld [2], e_wrap [2];

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_acc[i] = 0; m_ftw[i] = 0; m_sh_ftw[i] = 0;
      m_pofs[i] = 0; m_wave[i] = 0; m_sh_pofs[i] = 0; m_sh_wave[i] = 0;
      m_pend[i] = 0; m_cry[i] = 0;
      for (int j = 0; j < 3; j++) begin
        dl_p[i][j] = 0; dl_w[i][j] = 0; dl_v[i][j] = 0; dl_r[i][j] = 0;
      end
      e_data[i] = 0; e_vld[i] = 0; e_wrap[i] = 0;
    end
  endtask

  task automatic model_step(input int i);
    longint sum;
    bit carry, rdy, load;
    // a sample from the present phase enters a three-cycle delay line
    for (int j = 2; j > 0; j--) begin
      dl_p[i][j] = dl_p[i][j-1]; dl_w[i][j] = dl_w[i][j-1];
      dl_v[i][j] = dl_v[i][j-1]; dl_r[i][j] = dl_r[i][j-1];
    end
    dl_p[i][0] = int'(((m_acc[i] >> (ACC_W - ADDR_W)) + longint'(m_pofs[i])) % NP);
    dl_w[i][0] = m_wave[i];
    dl_v[i][0] = en;
    dl_r[i][0] = en && m_cry[i];
    e_vld[i]  = dl_v[i][2];
    e_wrap[i] = dl_r[i][2];
    if (dl_v[i][2]) e_data[i] = exp_sample(dl_p[i][2], dl_w[i][2]);
    // phase and configuration
    sum   = m_acc[i] + m_ftw[i];
    carry = (sum >= MOD);
    rdy   = (i == 0) ? 1'b1 : !m_pend[i];
    load  = (i == 0) ? m_pend[i] : (m_pend[i] && (phase_clr || (en && carry)));
    if (phase_clr) begin
      m_acc[i] = 0; m_cry[i] = 0;
    end else if (en) begin
      m_acc[i] = sum % MOD; m_cry[i] = carry;
    end
    if (load) begin
      m_ftw[i] = m_sh_ftw[i]; m_pofs[i] = m_sh_pofs[i]; m_wave[i] = m_sh_wave[i];
      m_pend[i] = 0;
    end
    if (cfg_vld && rdy) begin
      m_sh_ftw[i] = longint'(cfg_ftw); m_sh_pofs[i] = int'(cfg_pofs); m_sh_wave[i] = int'(cfg_wave);
      m_pend[i] = 1;
    end
  endtask

  always @(posedge s_clk or negedge s_rst_n) begin
    if (!s_rst_n) model_reset();
    else for (int i = 0; i < 2; i++) model_step(i);
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge s_clk) begin
    for (int i = 0; i < 2; i++) begin
      chk("model_data", i, int'(wave_data[i]), e_data[i]);
      chk("model_vld",  i, int'(wave_vld[i]),  int'(e_vld[i]));
      chk("model_wrap", i, int'(wrap[i]),      int'(e_wrap[i]));
      chk("model_rdy",  i, int'(cfg_rdy[i]),   (i == 0) ? 1 : int'(!m_pend[i]));
    end
  end

  // ---------------- stimulus ----------------
  int cap [2][1100];
  int cwr [2][1100];

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge s_clk);
      #1;
    end
  endtask

  task automatic offer(input logic [ACC_W-1:0] f, input logic [ADDR_W-1:0] p, input logic [1:0] w);
    cfg_vld = 1'b1; cfg_ftw = f; cfg_pofs = p; cfg_wave = w;
    tick(1);
    cfg_vld = 1'b0;
  endtask

  // clear the phase with en low, then run; returns with sample 0 on the output
  task automatic restart();
    en = 1'b0;
    phase_clr = 1'b1;
    tick(1);
    phase_clr = 1'b0;
    en = 1'b1;
    tick(3);
  endtask

  task automatic capture(input int n);
    for (int k = 0; k < n; k++) begin
      for (int i = 0; i < 2; i++) begin
        cap[i][k] = int'(wave_data[i]);
        cwr[i][k] = int'(wrap[i]);
      end
      tick(1);
    end
  endtask

  initial begin
    // 1: reset, then en with ftw = 0 holds the phase at 0
    tick(2);
    s_rst_n = 1'b1;
    tick(1);
    for (int i = 0; i < 2; i++) begin
      chk("rst_data", i, int'(wave_data[i]), 0);
      chk("rst_vld",  i, int'(wave_vld[i]),  0);
      chk("rst_rdy",  i, int'(cfg_rdy[i]),   1);
    end
    en = 1'b1;
    tick(2);
    chk("lat_vld_early", 0, int'(wave_vld[0]), 0);
    tick(1);
    chk("lat_vld", 0, int'(wave_vld[0]), 1);
    chk("hold_phase", 0, int'(wave_data[0]), 128);
    tick(5);
    chk("hold_phase_later", 1, int'(wave_data[1]), 128);

    // 2: sine, one table step per sample
    en = 1'b0;
    offer(32'd4194304, 10'd0, 2'd0);
    chk("pend_rdy", 1, int'(cfg_rdy[1]), 0);
    phase_clr = 1'b1;
    tick(1);
    phase_clr = 1'b0;
    chk("clr_applies", 1, int'(cfg_rdy[1]), 1);
    en = 1'b1;
    tick(3);
    capture(1030);
    chk("sin_p0",   0, cap[0][0],   128);
    chk("sin_p255", 0, cap[0][255], 255);
    chk("sin_p256", 0, cap[0][256], 255);
    chk("sin_p511", 0, cap[0][511], 128);
    chk("sin_p512", 1, cap[1][512], 127);
    chk("sin_wrap0",    0, cwr[0][0],    0);
    chk("sin_wrap1023", 0, cwr[0][1023], 0);
    chk("sin_wrap1024", 1, cwr[1][1024], 1);
    for (int n = 0; n < 512; n += 64) chk("sin_sym", 0, cap[0][n] + cap[0][1023-n], 255);

    // 3: sawtooth and square at four phase steps per sample
    en = 1'b0;
    offer(32'd16777216, 10'd0, 2'd3);
    restart();
    capture(260);
    chk("saw_0",   0, cap[0][0],   0);
    chk("saw_1",   0, cap[0][1],   1);
    chk("saw_255", 1, cap[1][255], 255);
    chk("saw_256", 0, cap[0][256], 0);
    chk("saw_wrap255", 0, cwr[0][255], 0);
    chk("saw_wrap256", 0, cwr[0][256], 1);
    en = 1'b0;
    offer(32'd16777216, 10'd0, 2'd1);
    restart();
    capture(260);
    chk("sqr_0",   0, cap[0][0],   255);
    chk("sqr_127", 0, cap[0][127], 255);
    chk("sqr_128", 1, cap[1][128], 0);
    chk("sqr_255", 0, cap[0][255], 0);

    // 4: cosine via phase offset, then triangle
    en = 1'b0;
    offer(32'd4194304, 10'd256, 2'd0);
    restart();
    chk("cos_peak", 0, int'(wave_data[0]), 255);
    chk("cos_peak_vld", 1, int'(wave_vld[1]), 1);
    en = 1'b0;
    offer(32'd4194304, 10'd0, 2'd2);
    restart();
    capture(520);
    chk("tri_0",   0, cap[0][0],   0);
    chk("tri_1",   0, cap[0][1],   0);
    chk("tri_2",   0, cap[0][2],   1);
    chk("tri_511", 0, cap[0][511], 255);
    chk("tri_512", 1, cap[1][512], 255);
    chk("tri_514", 0, cap[0][514], 254);

    // 5: wrap-synchronous update, second offer while pending is refused
    en = 1'b0;
    offer(32'd16777216, 10'd0, 2'd3);
    restart();
    for (int k = 0; k < 780; k++) begin
      for (int i = 0; i < 2; i++) begin
        cap[i][k] = int'(wave_data[i]);
        cwr[i][k] = int'(wrap[i]);
      end
      if (k == 101) chk("wrap_pend_rdy", 1, int'(cfg_rdy[1]), 0);
      if (k == 300) chk("wrap_rdy_back", 1, int'(cfg_rdy[1]), 1);
      cfg_vld = (k == 100) || (k == 101);
      cfg_ftw = (k == 100) ? 32'd8388608 : 32'd2097152;
      cfg_wave = (k == 100) ? 2'd3 : 2'd1;
      tick(1);
    end
    cfg_vld = 1'b0;
    chk("upd_255", 1, cap[1][255], 255);
    chk("upd_256", 1, cap[1][256], 0);
    chk("upd_wrap", 1, cwr[1][256], 1);
    chk("upd_257", 1, cap[1][257], 0);
    chk("upd_258", 1, cap[1][258], 1);
    chk("upd_259", 1, cap[1][259], 1);
    chk("upd_wrap768", 1, cwr[1][768], 1);
    chk("upd_770", 1, cap[1][770], 1);

    // 6: reset mid-stream with a pending config
    offer(32'd1048576, 10'd0, 2'd1);
    chk("pre_rst_pend", 1, int'(cfg_rdy[1]), 0);
    tick(5);
    s_rst_n = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      chk("async_data", i, int'(wave_data[i]), 0);
      chk("async_vld",  i, int'(wave_vld[i]),  0);
      chk("async_wrap", i, int'(wrap[i]),      0);
      chk("async_rdy",  i, int'(cfg_rdy[i]),   1);
    end
    tick(2);
    s_rst_n = 1'b1;
    tick(3);
    chk("post_rst_vld", 1, int'(wave_vld[1]), 1);
    chk("post_rst_data", 1, int'(wave_data[1]), 128);
    tick(20);
    chk("post_rst_hold", 1, int'(wave_data[1]), 128);
    chk("post_rst_rdy", 1, int'(cfg_rdy[1]), 1);

    tick(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
